// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each input word to one of N_CH independent
// circular buffers selected by in_sel; out-of-range words are dropped and counted.
module demux_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic                     sel_err,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam logic [7:0]  DROP_MAX = 8'hFF;

    logic [DATA_W-1:0] mem    [N_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_CH];
    logic [PTR_W-1:0]  rd_ptr [N_CH];
    logic [CNT_W-1:0]  count  [N_CH];

    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    logic            out_of_range;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Select decode and handshake; in_ready looks only at the addressed channel's count.
    always_comb begin
        hit          = '0;
        push         = '0;
        pop          = '0;
        in_ready     = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            hit[i]  = (in_sel == SEL_W'(i));
            if (hit[i]) begin
                in_ready = (count[i] != CNT_W'(DEPTH));
            end
            push[i] = in_valid & hit[i] & (count[i] != CNT_W'(DEPTH));
            pop[i]  = out_ready[i] & (count[i] != '0);
        end
        out_of_range = ~|hit;
    end

    // Channel heads are read straight from buffer storage.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int i = 0; i < N_CH; i++) begin
            out_valid[i]                     = (count[i] != '0);
            out_data[i*DATA_W +: DATA_W]     = mem[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_data;
                    wr_ptr[i]         <= next_ptr(wr_ptr[i]);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= next_ptr(rd_ptr[i]);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
            // Out-of-range words are always accepted, then discarded.
            sel_err <= in_valid & out_of_range;
            if (in_valid && out_of_range && drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each data word.
REQ-002 SHALL have parameter N_CH, default 4: number of output channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2: select width, and SHALL satisfy 2**SEL_W >= N_CH.
REQ-004 SHALL have parameter DEPTH, default 2: per-channel buffer entries, legal range 2..16, power of two not required.
REQ-005 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous and active-high.
REQ-007 Port: in_data  input  DATA_W  word to route.
REQ-008 Port: in_sel  input  SEL_W  destination channel index.
REQ-009 Port: in_valid  input  1  in_data/in_sel valid.
REQ-010 Port: in_ready  output  1  block accepts the word this cycle.
REQ-011 Port: out_data  output  N_CH*DATA_W  channel i head word at bits [i*DATA_W +: DATA_W].
REQ-012 Port: out_valid  output  N_CH  bit i set when channel i holds at least one word.
REQ-013 Port: out_ready  input  N_CH  bit i set when the channel i consumer takes the head word.
REQ-014 Port: sel_err  output  1  one-cycle pulse when an out-of-range word is dropped.
REQ-015 Port: drop_cnt  output  8  saturating count of dropped words.

Function
REQ-016 Transfer in: a word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be combinational from in_sel and the registered channel state only; it SHALL NOT depend on out_ready.
REQ-018 For in_sel < N_CH, in_ready SHALL be 1 when count[in_sel] < DEPTH and 0 when the channel is full.
REQ-019 For in_sel >= N_CH, in_ready SHALL be 1.
REQ-020 An accepted out-of-range word SHALL be discarded, SHALL pulse sel_err high for exactly the following cycle, and SHALL increment drop_cnt.
REQ-021 drop_cnt SHALL hold at 255 once it reaches 255.
REQ-022 Each channel SHALL be an independent circular buffer of DEPTH entries with write pointer, read pointer and count (0..DEPTH).
REQ-023 Latency: a word accepted at edge k SHALL be visible on out_valid/out_data of its channel after edge k, i.e. one cycle, with no combinational pass-through.
REQ-024 out_valid[i] SHALL equal (count[i] != 0), and out_data slice i SHALL be the entry at the read pointer of channel i.
REQ-025 Transfer out: the head of channel i SHALL be popped on an edge where out_valid[i]=1 and out_ready[i]=1.
REQ-026 out_ready[i] asserted while out_valid[i]=0 SHALL have no effect.
REQ-027 A push and a pop on the same channel in the same edge SHALL leave count unchanged and advance both pointers. On a full channel only the pop occurs, because in_ready=0.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 Channels SHALL be independent: pops on any channel set SHALL occur concurrently with a push to any channel.
REQ-030 A stalled or full channel SHALL block only words addressed to it.
REQ-031 Word order within each channel SHALL be preserved (FIFO order).
REQ-032 When in_valid=0, state SHALL change only through pops.

Reset
REQ-033 While rst=1, regardless of clk: all counts and pointers SHALL be 0, out_valid SHALL be all 0, out_data SHALL be all 0, sel_err SHALL be 0, and drop_cnt SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered words immediately.
REQ-035 No output transfer SHALL occur on the first edge after rst deasserts unless a word was accepted on that edge.

Verification
REQ-036 Routing: with DATA_W=8, N_CH=4, out_ready=4'b1111, drive in_valid=1 with in_sel=0,1,2,3 and in_data=8'hA0..8'hA3 on consecutive cycles. Each word SHALL appear on its channel exactly one cycle after acceptance, and other channels' out_valid SHALL stay 0.
REQ-037 Full/backpressure: out_ready=0, push 8'h11 and 8'h22 to channel 2. in_ready SHALL drop to 0 while in_sel=2 and SHALL be 1 for in_sel=1. Then set out_ready[2]=1: the channel SHALL yield 8'h11 then 8'h22, then out_valid[2]=0.
REQ-038 Simultaneous push/pop: channel 1 holds one word, out_ready[1]=1, push 8'h55 to channel 1 on the same edge. count SHALL remain 1 and the head SHALL become 8'h55.
REQ-039 Wrap-around: 6 push/pop pairs through channel 3 with DEPTH=2 SHALL deliver all 6 values in order.
REQ-040 Out-of-range select: N_CH=3, SEL_W=2, in_sel=3, in_data=8'hFF. in_ready SHALL be 1, sel_err SHALL pulse once, drop_cnt SHALL go 0 to 1, and no out_valid SHALL rise. After 256 such drops, drop_cnt SHALL read 255.
REQ-041 Async reset: assert rst between clock edges with channels 0 and 2 non-empty. out_valid SHALL read 0 and drop_cnt SHALL read 0 before the next rising edge.
